// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, EX redirects,
// data-memory freeze, halt latching and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DMEM_TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_dmem_ready,
  input  logic             i_wb_halt,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_bubble,
  output logic             o_halted,
  output logic             o_dmem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic [1:0]       o_dbg_state
);

  localparam int WAIT_W = $clog2(DMEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_freeze, w_lu, w_stall_inc, w_flush_inc;

  assign w_freeze = i_mem_req & ~i_dmem_ready;
  assign w_lu     = i_ex_mem_read & (i_ex_rd_addr != 5'd0) &
                    ((i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr)) |
                     (i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr)));

  assign w_stall_inc = (r_state != ST_HALTED) & (w_freeze | (w_lu & ~i_ex_redirect));
  assign w_flush_inc = (r_state != ST_HALTED) & i_ex_redirect & ~w_freeze;

  // A halt in WB wins over an outstanding wait: that instruction was latched before the freeze.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    case (r_state)
      ST_RUN: begin
        if (i_wb_halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_freeze) begin
          w_state_nxt    = ST_DWAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_DWAIT: begin
        if (i_wb_halt) begin
          w_state_nxt    = ST_HALTED;
          w_wait_cnt_nxt = '0;
        end else if (i_dmem_ready) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    o_pc_en         = 1'b0;
    o_if_id_en      = 1'b0;
    o_if_id_flush   = 1'b0;
    o_id_ex_en      = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_ex_mem_en     = 1'b0;
    o_mem_wb_bubble = 1'b0;
    if (!i_rst_n) begin
      o_if_id_flush   = 1'b1;
      o_id_ex_flush   = 1'b1;
      o_mem_wb_bubble = 1'b1;
    end else if (r_state == ST_HALTED) begin
      o_pc_en = 1'b0;
    end else if (w_freeze) begin
      o_mem_wb_bubble = 1'b1;
    end else if (i_ex_redirect) begin
      o_pc_en       = 1'b1;
      o_if_id_en    = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_en    = 1'b1;
      o_id_ex_flush = 1'b1;
      o_ex_mem_en   = 1'b1;
    end else if (w_lu) begin
      // Hold PC and IF/ID one cycle; the bubble lets the load reach MEM for forwarding.
      o_id_ex_en    = 1'b1;
      o_id_ex_flush = 1'b1;
      o_ex_mem_en   = 1'b1;
    end else begin
      o_pc_en     = 1'b1;
      o_if_id_en  = 1'b1;
      o_id_ex_en  = 1'b1;
      o_ex_mem_en = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_halted       = (r_state == ST_HALTED);
  assign o_dmem_timeout = r_timeout;
  assign o_stall_cycles = r_stall_cnt;
  assign o_flush_count  = r_flush_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed steps then random cycles, every cycle checked
// against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, ex_rd;
  logic          u1, u2, ex_rd_en, redir, mem_req, ready, halt;
  logic          pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, bubble;
  logic          halted, timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_halted, m_dwait, m_timeout;
  int m_streak, m_stall, m_flush;

  pipe_hazard_ctrl #(.CNT_W(CW), .DMEM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
    .i_ex_rd_addr(ex_rd), .i_ex_mem_read(ex_rd_en),
    .i_ex_redirect(redir), .i_mem_req(mem_req), .i_dmem_ready(ready),
    .i_wb_halt(halt),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_fl),
    .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_fl), .o_ex_mem_en(ex_mem_en),
    .o_mem_wb_bubble(bubble), .o_halted(halted), .o_dmem_timeout(timeout),
    .o_stall_cycles(stall_cnt), .o_flush_count(flush_cnt), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return ex_rd_en && (ex_rd != 0) && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
  endfunction

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}
  task automatic expected_ctrl(output logic [6:0] exp, output logic [6:0] msk);
    bit frz;
    frz = mem_req && !ready;
    msk = 7'b111_1111;
    if (!rst_n)          exp = 7'b001_0101;
    else if (m_halted)   exp = 7'b000_0000;
    else if (frz)        exp = 7'b000_0001;
    else if (redir)      exp = 7'b111_1110;
    else if (hazard()) begin
      exp = 7'b000_0110;
      msk = 7'b111_0111;  // ID/EX enable is irrelevant while its flush is asserted
    end else             exp = 7'b110_1010;
  endtask

  task automatic model_update();
    bit frz;
    frz = mem_req && !ready;
    if (!rst_n) begin
      m_halted = 0; m_dwait = 0; m_timeout = 0;
      m_streak = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (frz || (hazard() && !redir)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (redir && !frz)               m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (halt) begin
        m_halted = 1; m_dwait = 0; m_streak = 0;
      end else if (!m_dwait) begin
        if (frz) begin m_dwait = 1; m_streak = 1; end
      end else if (ready) begin
        m_dwait = 0; m_streak = 0;
      end else begin
        m_streak++;
        if (m_streak >= TO) m_timeout = 1;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [6:0] obs, exp, msk;
    @(negedge clk);
    expected_ctrl(exp, msk);
    obs = {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, bubble};
    check({tag, "_ctrl"}, 32'(obs & msk), 32'(exp & msk));
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
    check({tag, "_timeout"}, 32'(timeout), 32'(m_timeout));
    check({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "_flush"}, 32'(flush_cnt), 32'(m_flush));
    check({tag, "_state"}, 32'(dbg_state), m_halted ? 32'd2 : (m_dwait ? 32'd1 : 32'd0));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; ex_rd = 0; u1 = 0; u2 = 0; ex_rd_en = 0;
    redir = 0; mem_req = 0; ready = 0; halt = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_halted = 0; m_dwait = 0; m_timeout = 0; m_streak = 0; m_stall = 0; m_flush = 0;
    step("reset");
    rst_n = 1'b1;
    step("idle");

    // Load into x5 followed by a dependent add
    ex_rd_en = 1; ex_rd = 5; rs1 = 5; u1 = 1; rs2 = 1; u2 = 1;
    step("lu");
    ex_rd_en = 0;
    step("lu_next");
    check("lu_stall_count", 32'(stall_cnt), 32'd1);

    // x0 destination never stalls
    ex_rd_en = 1; ex_rd = 0; rs1 = 0; u1 = 1; rs2 = 0; u2 = 1;
    step("x0");
    idle_inputs();

    // Redirect outranks load-use
    ex_rd_en = 1; ex_rd = 7; rs1 = 7; u1 = 1; redir = 1;
    step("redir_lu");
    idle_inputs();
    step("redir_after");

    // Memory not ready for three cycles
    mem_req = 1; ready = 0;
    repeat (3) step("freeze");
    ready = 1;
    step("freeze_rdy");
    mem_req = 0;
    step("freeze_after");

    // Not ready long enough to trip the timeout
    mem_req = 1; ready = 0;
    repeat (5) step("tmo");
    ready = 1;
    step("tmo_rdy");
    mem_req = 0;
    step("tmo_after");
    check("tmo_sticky", 32'(timeout), 32'd1);

    rst_n = 0;
    step("tmo_reset");
    rst_n = 1;

    // Flush counter saturation
    redir = 1;
    repeat (20) step("redir_sat");
    redir = 0;
    step("redir_sat_end");
    check("flush_saturated", 32'(flush_cnt), 32'd15);

    // Halt is terminal until reset
    halt = 1;
    step("halt");
    halt = 0; redir = 1; mem_req = 1; ex_rd_en = 1; ex_rd = 3; rs1 = 3; u1 = 1;
    repeat (3) step("halted");
    idle_inputs();
    rst_n = 0;
    step("halt_reset");
    rst_n = 1;
    step("post_reset");

    for (int i = 0; i < 2000; i++) begin
      rst_n    = ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      halt     = ($urandom_range(0, 99) == 0);
      mem_req  = ($urandom_range(0, 2) == 0);
      ready    = 1'($urandom_range(0, 1));
      redir    = ($urandom_range(0, 4) == 0);
      ex_rd_en = 1'($urandom_range(0, 1));
      ex_rd    = 5'($urandom_range(0, 3));
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      u1       = 1'($urandom_range(0, 1));
      u2       = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
